vector_mem_access_unit: RTL

- MEM-stage memory sequencer for the vector CPU.
- Converts one vector load or store of R lanes × N bits into R sequential accesses to a single-port, N-bit-wide synchronous data memory.
- For loads, assembles the lanes into ReadDataM, which the MEM/WB segment register captures.
- Holds the pipeline with StallM while a transfer is in flight.

---
 rtl/vector_mem_access_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/vector_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : vector_mem_access_unit
//  Purpose  : MEM-stage sequencer that turns one R-lane vector load or store
//             into R sequential accesses to a single-port N-bit memory.
//  Revision : 1.0 - initial release
// ============================================================================
module vector_mem_access_unit #(
  parameter int I = 32,
  parameter int N = 8,
  parameter int R = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemReadM,
  input  logic                MemWriteM,
  input  logic [I-1:0]        AddrM,
  input  logic [R-1:0][N-1:0] WriteDataM,
  output logic [R-1:0][N-1:0] ReadDataM,
  output logic                StallM,
  output logic                DoneM,
  output logic [I-1:0]        mem_addr,
  output logic                mem_we,
  output logic [N-1:0]        mem_wdata,
  input  logic [N-1:0]        mem_rdata
);

  // Counter must reach R (the extra READ cycle that collects the last lane).
  localparam int CW = $clog2(R + 1);
  localparam logic [CW-1:0] c_last_rd = CW'(R);
  localparam logic [CW-1:0] c_last_wr = CW'(R - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [I-1:0]          r_base;
  logic [R-1:0][N-1:0]   r_data;
  logic [R-1:0][N-1:0]   r_rdata;
  logic [CW-1:0]         r_j;
  logic [CW-1:0]         w_jm1;
  logic                  w_req;

  assign w_req     = MemReadM | MemWriteM;
  // Lane index for the data returning from the address issued last cycle.
  assign w_jm1     = r_j - CW'(1);
  assign ReadDataM = r_rdata;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and memory-side / pipeline-side outputs.
  always_comb begin
    w_next    = r_state;
    StallM    = 1'b0;
    DoneM     = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (r_state)
      S_IDLE: begin
        // Gated by reset so the hold is released the instant reset asserts.
        StallM = w_req & ~reset;
        if (MemWriteM) begin
          w_next = S_WRITE;       // store wins when both are requested
        end else if (MemReadM) begin
          w_next = S_READ;
        end
      end
      S_READ: begin
        StallM = 1'b1;
        if (r_j < c_last_rd) begin
          mem_addr = r_base + I'(r_j);
        end
        if (r_j == c_last_rd) begin
          w_next = S_DONE;
        end
      end
      S_WRITE: begin
        StallM    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = r_base + I'(r_j);
        mem_wdata = r_data[r_j];
        if (r_j == c_last_wr) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        // Always returns to IDLE so a lingering request is not re-issued here.
        DoneM  = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Request capture, lane counter and progressive load-data assembly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base  <= '0;
      r_data  <= '0;
      r_rdata <= '0;
      r_j     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_base <= AddrM;
            r_data <= WriteDataM;
            r_j    <= '0;
          end
        end
        S_READ: begin
          r_j <= r_j + CW'(1);
          if (r_j != '0) begin
            r_rdata[w_jm1] <= mem_rdata;
          end
        end
        S_WRITE: begin
          r_j <= r_j + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
